player_bullet: RTL and testbench
================================

Name: player_bullet

Overview:
- Player-side shooter; the source end of each enemy's hit_i input.
- Launches a single bullet from the player ship and moves it up the screen once per frame.
- Checks the bullet box against every live enemy box each cycle and returns a one-cycle hit pulse to the enemy that was struck.
- Sits between the player ship, the enemy array and the VGA pixel mux.

Parameters:
- num_enemies_p, 4, number of enemy instances checked.
- step_p, 10'd8, pixels the bullet rises per frame_i.
- bullet_w_p, 10'd2, bullet width in pixels.
- bullet_h_p, 10'd8, bullet height in pixels.
- muzzle_off_p, 10'd19, x offset added to player_left_i at launch.
- reload_frames_p, 10'd30, frames of cooldown after the bullet retires.
- color_p, 12'hF00, bullet RGB.

Ports:
- clk_i  in  1  pixel/system clock
- reset_ni  in  1  asynchronous active-low reset
- frame_i  in  1  one-cycle pulse per processed frame
- fire_i  in  1  fire request (level; edge not required)
- player_left_i  in  10  player ship left x
- player_top_i  in  10  player ship top y
- enemy_left_i  in  10*num_enemies_p  packed enemy left x, enemy 0 at LSBs
- enemy_right_i  in  10*num_enemies_p  packed enemy right x
- enemy_top_i  in  10*num_enemies_p  packed enemy top y
- enemy_bot_i  in  10*num_enemies_p  packed enemy bottom y (bot >= top)
- enemy_dead_i  in  num_enemies_p  enemy dead flags
- hit_o  out  num_enemies_p  one-hot, one-cycle hit pulse per enemy
- score_inc_o  out  1  one-cycle pulse, concurrent with any hit_o bit
- bullet_active_o  out  1  bullet visible
- bullet_left_o  out  10  bullet left x
- bullet_top_o  out  10  bullet top y
- bullet_red_o, bullet_green_o, bullet_blue_o  out  4 each  color_p slices

Behaviour:
- Async reset (reset_ni=0): state READY; hit_o=0; score_inc_o=0; bullet_active_o=0; bullet_left_o=0; bullet_top_o=0; cooldown=0. Release is synchronous to clk_i.
- States: READY, FLYING, STRIKE, RELOAD.
- READY:
  - fire_i=1 -> FLYING on the next edge.
  - Latches bullet_left = player_left_i + muzzle_off_p.
  - Latches bullet_top = player_top_i - bullet_h_p. Arithmetic is 10-bit; if player_top_i < bullet_h_p, load 0.
- FLYING:
  - bullet_active_o=1.
  - Overlap with enemy k: ~enemy_dead_i[k] & bl <= right[k] & bl+bullet_w_p-1 >= left[k] & bt <= bot[k] & bt+bullet_h_p-1 >= top[k]. All comparisons unsigned, 10-bit.
  - Any overlap -> STRIKE. Collision has priority over a same-cycle frame_i; the position is not updated that cycle.
  - Else on frame_i: if bullet_top < step_p -> RELOAD (off-screen, no hit). Otherwise bullet_top -= step_p.
  - fire_i is ignored while FLYING. No queueing.
- STRIKE: exactly one cycle.
  - hit_o has one bit set: the lowest-index overlapping enemy. score_inc_o=1.
  - bullet_active_o=0.
  - Next state RELOAD.
- RELOAD:
  - Cooldown counter is loaded with 0 on entry and incremented per frame_i.
  - When the counter reaches reload_frames_p -> READY. Exactly reload_frames_p frame_i pulses are needed.
  - If reload_frames_p=0, go to READY on the next cycle.
- hit_o and score_inc_o are registered outputs; they are 0 in every state except STRIKE.
- An enemy that becomes dead mid-flight is excluded from that cycle onward.
- An enemy whose dead flag rises in the same cycle as an overlap is not hit.
- Reset mid-flight: the bullet vanishes at once and hit_o is 0, including when reset lands in STRIKE.
- Colour outputs are constant slices of color_p; the pixel mux gates them with bullet_active_o.

Decomposition:
- Package space_pkg holds:
  - the state enum (4-bit one-hot plus ERROR=0, same encoding style as the enemy FSM)
  - screen constants (width 640, height 480)
  - the default bullet dimensions.
- Reuse the existing counter module (width 10, step 1) for the reload cooldown.
- One combinational sub-module, box_overlap: two boxes in, overlap flag out. Generated num_enemies_p times, followed by a priority encoder to one-hot.

Test Plan:
1. Reset, then fire_i with player_left_i=300, player_top_i=440 -> next cycle bullet_active_o=1, bullet_left_o=319, bullet_top_o=432. After 3 frame_i pulses, bullet_top_o=408.
2. Enemy 2 box at x 310..350, y 100..110, alive; fly the bullet up -> hit_o=4'b0100 for exactly one cycle. In the same cycle score_inc_o=1 and bullet_active_o=0.
3. Enemies 1 and 3 both overlap the bullet in the same cycle -> hit_o=4'b0010 only.
4. Enemy 2 at the same box but enemy_dead_i[2]=1 -> no hit_o. Bullet continues to bullet_top_o<8, then retires. hit_o stays 0 throughout.
5. After retire, hold fire_i=1 -> no relaunch for 29 frames; launch after the 30th frame_i. fire_i during flight has no effect.
6. Assert reset_ni=0 asynchronously in the STRIKE cycle -> hit_o and bullet_active_o drop to 0 immediately; after release, state is READY.

Source files
------------

// File: rtl/space_pkg.sv
// space_pkg: shared state encoding, screen geometry and bullet defaults
package space_pkg;
  typedef enum logic [3:0] {
    st_error  = 4'b0000,
    st_ready  = 4'b0001,
    st_flying = 4'b0010,
    st_strike = 4'b0100,
    st_reload = 4'b1000
  } bullet_state_e;
  localparam logic [9:0] screen_w_lp = 10'd640;
  localparam logic [9:0] screen_h_lp = 10'd480;
  localparam logic [9:0] bullet_w_lp = 10'd2;
  localparam logic [9:0] bullet_h_lp = 10'd8;
endpackage

// File: rtl/box_overlap.sv
// box_overlap: inclusive axis-aligned overlap test between two boxes
module box_overlap (
  input  logic [9:0] a_left_i,
  input  logic [9:0] a_right_i,
  input  logic [9:0] a_top_i,
  input  logic [9:0] a_bot_i,
  input  logic [9:0] b_left_i,
  input  logic [9:0] b_right_i,
  input  logic [9:0] b_top_i,
  input  logic [9:0] b_bot_i,
  output logic       overlap_o
);
  assign overlap_o = (a_left_i <= b_right_i) && (a_right_i >= b_left_i) &&
                     (a_top_i <= b_bot_i) && (a_bot_i >= b_top_i);
endmodule

// File: rtl/counter.sv
// counter: clearable up-counter advancing by step_p when enabled
module counter #(
  parameter int                 width_p = 10,
  parameter logic [width_p-1:0] step_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);
  // clear wins over enable so a fresh count always starts at zero
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) count_o <= '0;
    else if (clear_i) count_o <= '0;
    else if (en_i) count_o <= count_o + step_p;
endmodule

// File: rtl/player_bullet.sv
// player_bullet: single player bullet with launch, flight, enemy hit detection and reload
module player_bullet
  import space_pkg::*;
#(
  parameter int         num_enemies_p   = 4,
  parameter logic [9:0] step_p          = 10'd8,
  parameter logic [9:0] bullet_w_p      = bullet_w_lp,
  parameter logic [9:0] bullet_h_p      = bullet_h_lp,
  parameter logic [9:0] muzzle_off_p    = 10'd19,
  parameter logic [9:0] reload_frames_p = 10'd30,
  parameter logic [11:0] color_p        = 12'hF00
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       frame_i,
  input  logic                       fire_i,
  input  logic [9:0]                 player_left_i,
  input  logic [9:0]                 player_top_i,
  input  logic [10*num_enemies_p-1:0] enemy_left_i,
  input  logic [10*num_enemies_p-1:0] enemy_right_i,
  input  logic [10*num_enemies_p-1:0] enemy_top_i,
  input  logic [10*num_enemies_p-1:0] enemy_bot_i,
  input  logic [num_enemies_p-1:0]   enemy_dead_i,
  output logic [num_enemies_p-1:0]   hit_o,
  output logic                       score_inc_o,
  output logic                       bullet_active_o,
  output logic [9:0]                 bullet_left_o,
  output logic [9:0]                 bullet_top_o,
  output logic [3:0]                 bullet_red_o,
  output logic [3:0]                 bullet_green_o,
  output logic [3:0]                 bullet_blue_o
);
  bullet_state_e state_q, state_n;
  logic [9:0] left_n, top_n, cnt;
  logic [num_enemies_p-1:0] ov, hit_n;
  logic [9:0] b_right, b_bot;
  assign b_right = bullet_left_o + bullet_w_p - 10'd1;
  assign b_bot   = bullet_top_o + bullet_h_p - 10'd1;
  genvar k;
  generate
    for (k = 0; k < num_enemies_p; k++) begin : g_ov
      logic raw;
      box_overlap u_box (
        .a_left_i  (bullet_left_o),
        .a_right_i (b_right),
        .a_top_i   (bullet_top_o),
        .a_bot_i   (b_bot),
        .b_left_i  (enemy_left_i[10*k +: 10]),
        .b_right_i (enemy_right_i[10*k +: 10]),
        .b_top_i   (enemy_top_i[10*k +: 10]),
        .b_bot_i   (enemy_bot_i[10*k +: 10]),
        .overlap_o (raw)
      );
      assign ov[k] = raw & ~enemy_dead_i[k];
    end
  endgenerate
  counter #(.width_p(10), .step_p(10'd1)) u_cooldown (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (state_n == st_reload && state_q != st_reload),
    .en_i     (state_q == st_reload && frame_i),
    .count_o  (cnt)
  );
  // next state, bullet position and the lowest-index hit; collision beats frame motion
  always_comb begin
    state_n = state_q;
    left_n  = bullet_left_o;
    top_n   = bullet_top_o;
    hit_n   = '0;
    case (state_q)
      st_ready: if (fire_i) begin
        state_n = st_flying;
        left_n  = player_left_i + muzzle_off_p;
        top_n   = (player_top_i < bullet_h_p) ? 10'd0 : player_top_i - bullet_h_p;
      end
      st_flying: if (|ov) begin
        state_n = st_strike;
        hit_n   = ov & (-ov);
      end else if (frame_i) begin
        if (bullet_top_o < step_p) state_n = st_reload;
        else top_n = bullet_top_o - step_p;
      end
      st_strike: state_n = st_reload;
      st_reload: if (cnt == reload_frames_p) state_n = st_ready;
      default:   state_n = st_ready;
    endcase
  end
  // state, position and registered hit/score pulses
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q       <= st_ready;
      bullet_left_o <= '0;
      bullet_top_o  <= '0;
      hit_o         <= '0;
      score_inc_o   <= 1'b0;
    end else begin
      state_q       <= state_n;
      bullet_left_o <= left_n;
      bullet_top_o  <= top_n;
      hit_o         <= hit_n;
      score_inc_o   <= |hit_n;
    end
  assign bullet_active_o = state_q == st_flying;
  assign bullet_red_o    = color_p[11:8];
  assign bullet_green_o  = color_p[7:4];
  assign bullet_blue_o   = color_p[3:0];
endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed stimulus with a hit scoreboard and monitor
module tb_player_bullet;
  logic clk_i = 0, reset_ni = 0, frame_i = 0, fire_i = 0;
  logic [9:0] player_left_i = 0, player_top_i = 0;
  logic [39:0] enemy_left_i = 0, enemy_right_i = 0, enemy_top_i = 0, enemy_bot_i = 0;
  logic [3:0] enemy_dead_i = 4'hF;
  logic [3:0] hit_o;
  logic score_inc_o, bullet_active_o;
  logic [9:0] bullet_left_o, bullet_top_o, last_top;
  logic [3:0] bullet_red_o, bullet_green_o, bullet_blue_o;
  int checks = 0, failures = 0, hit_cnt = 0;
  logic [3:0] exp_q[$];

  player_bullet dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .fire_i(fire_i),
    .player_left_i(player_left_i), .player_top_i(player_top_i),
    .enemy_left_i(enemy_left_i), .enemy_right_i(enemy_right_i),
    .enemy_top_i(enemy_top_i), .enemy_bot_i(enemy_bot_i), .enemy_dead_i(enemy_dead_i),
    .hit_o(hit_o), .score_inc_o(score_inc_o), .bullet_active_o(bullet_active_o),
    .bullet_left_o(bullet_left_o), .bullet_top_o(bullet_top_o),
    .bullet_red_o(bullet_red_o), .bullet_green_o(bullet_green_o), .bullet_blue_o(bullet_blue_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frame();
    frame_i = 1;
    tick();
    frame_i = 0;
  endtask

  task automatic set_enemy(input int k, input logic [9:0] l, r, t, b);
    enemy_left_i[10*k +: 10]  = l;
    enemy_right_i[10*k +: 10] = r;
    enemy_top_i[10*k +: 10]   = t;
    enemy_bot_i[10*k +: 10]   = b;
  endtask

  task automatic reload_and_launch();
    fire_i = 1;
    player_left_i = 300;
    player_top_i = 440;
    repeat (29) frame();
    repeat (3) tick();
    chk("reload_29_no_launch", bullet_active_o, 0);
    frame();
    repeat (2) tick();
    chk("reload_30_launch", bullet_active_o, 1);
    chk("relaunch_left", bullet_left_o, 319);
    chk("relaunch_top", bullet_top_o, 432);
  endtask

  always @(negedge clk_i)
    if (reset_ni && (score_inc_o || hit_o != 0)) begin
      hit_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_hit hit_o=%b score_inc_o=%b", hit_o, score_inc_o);
      end else begin
        chk("hit_o", {28'd0, hit_o}, {28'd0, exp_q.pop_front()});
        chk("score_inc", score_inc_o, 1);
        chk("active_in_strike", bullet_active_o, 0);
      end
    end

  initial begin
    repeat (2) tick();
    chk("rst_active", bullet_active_o, 0);
    chk("rst_left", bullet_left_o, 0);
    chk("rst_top", bullet_top_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_score", score_inc_o, 0);
    chk("color", {bullet_red_o, bullet_green_o, bullet_blue_o}, 12'hF00);
    reset_ni = 1;
    tick();
    player_left_i = 300;
    player_top_i = 440;
    fire_i = 1;
    tick();
    fire_i = 0;
    chk("launch_active", bullet_active_o, 1);
    chk("launch_left", bullet_left_o, 319);
    chk("launch_top", bullet_top_o, 432);
    repeat (3) frame();
    chk("top_after_3", bullet_top_o, 408);
    set_enemy(2, 310, 350, 100, 110);
    enemy_dead_i = 4'b1011;
    exp_q.push_back(4'b0100);
    for (int i = 0; i < 60 && hit_cnt == 0; i++) frame();
    chk("strike2_seen", hit_cnt, 1);
    chk("collision_beats_frame", bullet_top_o, 104);
    tick();
    chk("hit_cleared", hit_o, 0);
    reload_and_launch();
    player_left_i = 100;
    tick();
    chk("fire_ignored_in_flight", bullet_left_o, 319);
    set_enemy(1, 300, 330, 200, 220);
    set_enemy(3, 315, 340, 200, 220);
    enemy_dead_i = 4'b0101;
    exp_q.push_back(4'b0010);
    for (int i = 0; i < 60 && hit_cnt == 1; i++) frame();
    chk("strike3_seen", hit_cnt, 2);
    chk("strike3_top", bullet_top_o, 216);
    tick();
    reload_and_launch();
    fire_i = 0;
    enemy_dead_i = 4'b1111;
    last_top = bullet_top_o;
    for (int i = 0; i < 80 && bullet_active_o; i++) begin
      last_top = bullet_top_o;
      frame();
    end
    chk("retired", bullet_active_o, 0);
    chk("retire_top_lt8", last_top < 10'd8, 1);
    chk("dead_no_hit", hit_cnt, 2);
    enemy_dead_i = 4'b1011;
    reload_and_launch();
    fire_i = 0;
    for (int i = 0; i < 60 && bullet_top_o != 104; i++) frame();
    chk("approach_top", bullet_top_o, 104);
    @(posedge clk_i);
    #2;
    chk("strike6_score", score_inc_o, 1);
    chk("strike6_hit", hit_o, 4'b0100);
    reset_ni = 0;
    #1;
    chk("async_rst_hit", hit_o, 0);
    chk("async_rst_active", bullet_active_o, 0);
    chk("async_rst_score", score_inc_o, 0);
    tick();
    reset_ni = 1;
    tick();
    chk("post_rst_idle", bullet_active_o, 0);
    fire_i = 1;
    tick();
    chk("post_rst_launch", bullet_active_o, 1);
    chk("post_rst_left", bullet_left_o, 319);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
